// File: rtl/sbox_sched.sv
// Shares one external pipelined AES S-box between a 16-byte state
// SubBytes job and a 4-byte key-schedule SubWord job.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   st_start/st_in    state job request and 128-bit operand
//   st_busy/st_done   state job in progress / completion pulse
//   st_out            substituted state (byte k = bits [8k+7:8k])
//   kw_start/kw_in    key word job request and 32-bit operand
//   kw_busy/kw_done   key word job in progress / completion pulse
//   kw_out            substituted key word
//   sb_x/sb_y         byte to the external S-box / its delayed result
module sbox_sched #(
    parameter int SBOX_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_start,
    input  logic [127:0] st_in,
    output logic         st_busy,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         kw_start,
    input  logic [31:0]  kw_in,
    output logic         kw_busy,
    output logic         kw_done,
    output logic [31:0]  kw_out,
    output logic [7:0]   sb_x,
    input  logic [7:0]   sb_y
);

    logic [127:0] st_op;
    logic [31:0]  kw_op;
    logic [3:0]   st_iss;
    logic [1:0]   kw_iss;
    logic         st_pend;
    logic         kw_pend;
    // 1 when st was served last, or nothing served since reset,
    // so that kw wins the next tie.
    logic         hist_st;

    // Tag pipeline running alongside the external S-box.
    logic [SBOX_LAT-1:0] tv;
    logic [SBOX_LAT-1:0] tid;
    logic [3:0]          tix [SBOX_LAT];

    logic       st_acc;
    logic       kw_acc;
    logic       gnt_st;
    logic       gnt_kw;
    logic       cap_v;
    logic       cap_st;
    logic [3:0] cap_ix;

    always_comb begin
        st_acc = st_start && !st_busy;
        kw_acc = kw_start && !kw_busy;
        gnt_kw = kw_pend && (!st_pend || hist_st);
        gnt_st = st_pend && !gnt_kw;
        cap_v  = tv[SBOX_LAT-1];
        cap_st = tid[SBOX_LAT-1];
        cap_ix = tix[SBOX_LAT-1];
        unique case (1'b1)
            gnt_kw:  sb_x = kw_op[{kw_iss, 3'b000} +: 8];
            gnt_st:  sb_x = st_op[{st_iss, 3'b000} +: 8];
            default: sb_x = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_op   <= '0;
            kw_op   <= '0;
            st_iss  <= '0;
            kw_iss  <= '0;
            st_pend <= 1'b0;
            kw_pend <= 1'b0;
            st_busy <= 1'b0;
            kw_busy <= 1'b0;
            st_done <= 1'b0;
            kw_done <= 1'b0;
            st_out  <= '0;
            kw_out  <= '0;
            hist_st <= 1'b1;
            tv      <= '0;
            tid     <= '0;
            for (int i = 0; i < SBOX_LAT; i++) begin
                tix[i] <= '0;
            end
        end else begin
            st_done <= 1'b0;
            kw_done <= 1'b0;

            tv[0]  <= gnt_kw || gnt_st;
            tid[0] <= gnt_st;
            tix[0] <= gnt_st ? st_iss : {2'b00, kw_iss};
            for (int i = 1; i < SBOX_LAT; i++) begin
                tv[i]  <= tv[i-1];
                tid[i] <= tid[i-1];
                tix[i] <= tix[i-1];
            end

            if (gnt_kw) begin
                kw_iss  <= kw_iss + 2'd1;
                hist_st <= 1'b0;
                if (kw_iss == 2'd3) kw_pend <= 1'b0;
            end
            if (gnt_st) begin
                st_iss  <= st_iss + 4'd1;
                hist_st <= 1'b1;
                if (&st_iss) st_pend <= 1'b0;
            end

            // Results return in issue order, so the last index
            // captured marks the end of the job.
            if (cap_v) begin
                if (cap_st) begin
                    st_out[{cap_ix, 3'b000} +: 8] <= sb_y;
                    if (&cap_ix) begin
                        st_done <= 1'b1;
                        st_busy <= 1'b0;
                    end
                end else begin
                    kw_out[{cap_ix[1:0], 3'b000} +: 8] <= sb_y;
                    if (cap_ix[1:0] == 2'd3) begin
                        kw_done <= 1'b1;
                        kw_busy <= 1'b0;
                    end
                end
            end

            if (st_acc) begin
                st_op   <= st_in;
                st_iss  <= '0;
                st_pend <= 1'b1;
                st_busy <= 1'b1;
            end
            if (kw_acc) begin
                kw_op   <= kw_in;
                kw_iss  <= '0;
                kw_pend <= 1'b1;
                kw_busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sbox_sched.sv
// Self-checking bench for sbox_sched: directed vectors at latency 4
// plus randomized scoreboard runs at latencies 1, 4 and 8.
module tb_sbox_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst = 1'b1;
    logic [2:0]          st_start = '0;
    logic [2:0]          kw_start = '0;
    logic [2:0]          st_busy, st_done, kw_busy, kw_done;
    logic [2:0][127:0]   st_in = '0;
    logic [2:0][127:0]   st_out;
    logic [2:0][31:0]    kw_in = '0;
    logic [2:0][31:0]    kw_out;
    logic [2:0][7:0]     sb_x, sb_y;

    logic [7:0] sbt [256];
    logic [7:0] sxl [41];
    int checks = 0;
    int failures = 0;
    logic [127:0] stq [$];
    logic [31:0]  kwq [$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
        logic [7:0] pipe [L];
        always_ff @(posedge clk) begin
            pipe[0] <= sbt[sb_x[g]];
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign sb_y[g] = pipe[L-1];
        sbox_sched #(.SBOX_LAT(L)) u_dut (
            .clk(clk), .rst(rst),
            .st_start(st_start[g]), .st_in(st_in[g]),
            .st_busy(st_busy[g]), .st_done(st_done[g]),
            .st_out(st_out[g]),
            .kw_start(kw_start[g]), .kw_in(kw_in[g]),
            .kw_busy(kw_busy[g]), .kw_done(kw_done[g]),
            .kw_out(kw_out[g]),
            .sb_x(sb_x[g]), .sb_y(sb_y[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                 ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] st_exp(input logic [127:0] v);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = sbt[v[8*b +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] kw_exp(input logic [31:0] v);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sbt[v[8*b +: 8]];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        st_start = '0;
        kw_start = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit           dk;
        logic [31:0]  kwv;
        logic [31:0]  kexp;
        int           kcyc;
        bit           ds;
        logic [127:0] stv;
        logic [127:0] sexp;
        int           scyc;
    } vec_t;

    vec_t tbl [5];

    localparam logic [127:0] ST_A = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] ST_AX = 128'h76abd7fe2b670130c56f6bf27b777c63;

    task automatic run_vec(input vec_t v, output int kc, output int sc,
                           output logic [31:0] ko, output logic [127:0] so,
                           output int nd, output logic [1:0] b1);
        do_reset();
        kw_start[1] = v.dk; kw_in[1] = v.kwv;
        st_start[1] = v.ds; st_in[1] = v.stv;
        kc = -1; sc = -1; nd = 0; ko = '0; so = '0; b1 = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            kw_start[1] = 1'b0;
            st_start[1] = 1'b0;
            sxl[c] = sb_x[1];
            if (c == 1) b1 = {kw_busy[1], st_busy[1]};
            if (kw_done[1]) begin
                nd++;
                if (kc < 0) begin kc = c; ko = kw_out[1]; end
            end
            if (st_done[1]) begin
                nd++;
                if (sc < 0) begin sc = c; so = st_out[1]; end
            end
        end
    endtask

    initial begin
        int kc, sc, nd;
        logic [31:0] ko;
        logic [127:0] so;
        logic [1:0] b1;
        logic [20:0] bad;
        logic [7:0] e;

        for (int i = 0; i < 256; i++) sbt[i] = sbox_calc(8'(i));

        tbl[0] = '{1'b1, 32'h0, 32'h63636363, 9, 1'b0, '0, '0, 0};
        tbl[1] = '{1'b0, 32'h0, 32'h0, 0, 1'b1, ST_A, ST_AX, 21};
        tbl[2] = '{1'b1, 32'h0, 32'h63636363, 12, 1'b1, ST_A, ST_AX, 25};
        tbl[3] = '{1'b1, 32'h53ff1001, 32'hed16ca7c, 9,
                   1'b0, '0, '0, 0};
        tbl[4] = '{1'b1, 32'h53ff1001, 32'hed16ca7c, 12,
                   1'b1, {128{1'b1}}, {16{8'h16}}, 25};

        do_reset();
        chk("rst_flags", {st_busy, st_done, kw_busy, kw_done}, '0);
        chk("rst_out", {kw_out[1], sb_x[1]}, '0);

        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i], kc, sc, ko, so, nd, b1);
            if (tbl[i].dk) begin
                chk($sformatf("vec%0d_kw_cycle", i), kc, tbl[i].kcyc);
                chk($sformatf("vec%0d_kw_out", i), ko, tbl[i].kexp);
            end
            if (tbl[i].ds) begin
                chk($sformatf("vec%0d_st_cycle", i), sc, tbl[i].scyc);
                chk($sformatf("vec%0d_st_out", i), so, tbl[i].sexp);
            end
            chk($sformatf("vec%0d_done_count", i), nd,
                int'(tbl[i].dk) + int'(tbl[i].ds));
            chk($sformatf("vec%0d_busy_c1", i), b1,
                {tbl[i].dk, tbl[i].ds});
            if (tbl[i].dk && tbl[i].ds) begin
                bad = '0;
                for (int c = 1; c <= 21; c++) begin
                    if (c == 21) e = 8'h00;
                    else if (c <= 7 && c % 2 == 1)
                        e = tbl[i].kwv[8*((c-1)/2) +: 8];
                    else if (c <= 8) e = tbl[i].stv[8*(c/2-1) +: 8];
                    else e = tbl[i].stv[8*(c-5) +: 8];
                    bad[c-1] = (sxl[c] !== e);
                end
                chk($sformatf("vec%0d_issue_order", i), bad, '0);
            end
        end

        // Start while busy is ignored.
        do_reset();
        st_start[1] = 1'b1; st_in[1] = ST_A;
        sc = -1; nd = 0; so = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            st_start[1] = (c == 5);
            if (c == 5) st_in[1] = {128{1'b1}};
            if (st_done[1]) begin
                nd++;
                if (sc < 0) begin sc = c; so = st_out[1]; end
            end
        end
        chk("restart_cycle", sc, 21);
        chk("restart_out", so, ST_AX);
        chk("restart_dones", nd, 1);

        // Reset in the middle of a state job.
        do_reset();
        st_start[1] = 1'b1; st_in[1] = ST_A;
        nd = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            st_start[1] = 1'b0;
            if (st_done[1]) nd++;
            if (c == 11) begin
                chk("midrst_flags", {st_busy[1], st_done[1], kw_busy[1],
                                     kw_done[1], sb_x[1]}, '0);
                chk("midrst_st_out", st_out[1], '0);
                rst = 1'b0;
            end
            if (c == 10) rst = 1'b1;
            if (c == 16) chk("midrst_inflight", st_out[1], '0);
        end
        chk("midrst_no_done", nd, 0);
        kw_start[1] = 1'b1; kw_in[1] = 32'h53ff1001;
        kc = -1; ko = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            kw_start[1] = 1'b0;
            if (kw_done[1] && kc < 0) begin kc = c; ko = kw_out[1]; end
        end
        chk("postrst_kw_cycle", kc, 9);
        chk("postrst_kw_out", ko, 32'hed16ca7c);

        // Randomized back-to-back traffic with a scoreboard.
        for (int k = 0; k < 3; k++) begin
            stq.delete();
            kwq.delete();
            do_reset();
            for (int c = 0; c < 460; c++) begin
                if (st_done[k]) begin
                    chk($sformatf("rand%0d_st_expected", k),
                        stq.size() > 0, 1);
                    if (stq.size() > 0)
                        chk($sformatf("rand%0d_st_out", k),
                            st_out[k], stq.pop_front());
                end
                if (kw_done[k]) begin
                    chk($sformatf("rand%0d_kw_expected", k),
                        kwq.size() > 0, 1);
                    if (kwq.size() > 0)
                        chk($sformatf("rand%0d_kw_out", k),
                            kw_out[k], kwq.pop_front());
                end
                if (c < 400) begin
                    st_start[k] = ($urandom_range(0, 3) != 0);
                    st_in[k] = {$urandom(), $urandom(),
                                $urandom(), $urandom()};
                    if (st_start[k] && !st_busy[k])
                        stq.push_back(st_exp(st_in[k]));
                    kw_start[k] = ($urandom_range(0, 3) != 0);
                    kw_in[k] = $urandom();
                    if (kw_start[k] && !kw_busy[k])
                        kwq.push_back(kw_exp(kw_in[k]));
                end else begin
                    st_start[k] = 1'b0;
                    kw_start[k] = 1'b0;
                end
                @(negedge clk);
            end
            chk($sformatf("rand%0d_st_left", k), stq.size(), 0);
            chk($sformatf("rand%0d_kw_left", k), kwq.size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sbox_sched.md
SBOX_SCHED -- requirements
Module: sbox_sched

Interface
REQ-001 SHALL have parameter SBOX_LAT, default 4: latency in cycles of the external pipelined sbox; legal range 1..8.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port st_start  input  1  one-cycle request to substitute all 16 bytes of st_in (state SubBytes job).
REQ-005 SHALL have port st_in  input  128  state operand, sampled only on an accepted st_start; byte k is bits [8k+7:8k].
REQ-006 SHALL have port st_busy  output  1  state job in progress.
REQ-007 SHALL have port st_done  output  1  one-cycle pulse marking state job completion.
REQ-008 SHALL have port st_out  output  128  substituted state, with the same byte mapping as st_in.
REQ-009 SHALL have port kw_start  input  1  one-cycle request to substitute the 4 bytes of kw_in (key-schedule SubWord job).
REQ-010 SHALL have port kw_in  input  32  key word operand, sampled only on an accepted kw_start.
REQ-011 SHALL have port kw_busy  output  1  key word job in progress.
REQ-012 SHALL have port kw_done  output  1  one-cycle pulse marking key word job completion.
REQ-013 SHALL have port kw_out  output  32  substituted key word.
REQ-014 SHALL have port sb_x  output  8  byte presented to the shared external sbox.
REQ-015 SHALL have port sb_y  input  8  external sbox result; sb_y in cycle n equals S(sb_x in cycle n-SBOX_LAT).

Function
REQ-016 SHALL accept xx_start only when xx_busy=0; a start with busy=1 is ignored without side effects.
REQ-017 SHALL treat the cycle in which a start is sampled high as cycle 0, register the operand, and assert busy from cycle 1.
REQ-018 SHALL issue at most one byte per cycle on sb_x, in ascending byte order within each job.
REQ-019 SHALL issue the first byte of an uncontended job in cycle 1.
REQ-020 SHALL alternate between requesters when both have pending bytes: the requester not served in the previous issue cycle wins, and kw wins when neither has yet been served since reset.
REQ-021 SHALL drive sb_x=8'h00 in cycles with no issue.
REQ-022 SHALL carry an SBOX_LAT-deep tag pipeline (valid, requester id, byte index) in step with the external sbox.
REQ-023 SHALL write sb_y into the tagged output byte at the end of the cycle in which the tag emerges.
REQ-024 SHALL pulse done, and deassert busy, in the cycle after the last byte of a job is captured; uncontended st_done occurs in cycle 17+SBOX_LAT and uncontended kw_done in cycle 5+SBOX_LAT.
REQ-025 SHALL hold xx_out stable from done until the first capture of that requester's next job; xx_out contents while busy=1 are don't-care.
REQ-026 SHALL accept a new start in the same cycle as the previous done of that requester.
REQ-027 SHALL allow a start for one requester while the other requester is busy; the new job joins arbitration from cycle 1.
REQ-028 SHALL never drop or reorder captured results, regardless of interleaving.

Reset
REQ-029 SHALL, on rst=1, clear st_busy, kw_busy, st_done and kw_done to 0, st_out to 128'h0, kw_out to 32'h0, sb_x to 8'h00, all tag valids, and the arbitration history (so kw wins the next tie).
REQ-030 SHALL, when rst is asserted mid-job, cancel all jobs, ignore sb_y for bytes in flight, and emit no done for cancelled jobs.
REQ-031 SHALL ignore st_start and kw_start in any cycle with rst=1.

Verification
REQ-032 SHALL cover: SBOX_LAT=4, kw_start with kw_in=32'h00000000 -> kw_done in cycle 9, kw_out=32'h63636363.
REQ-033 SHALL cover: SBOX_LAT=4, st_start with st_in=128'h0f0e0d0c0b0a09080706050403020100 -> st_done in cycle 21, st_out=128'h76abd7fe2b670130c56f6bf27b777c63.
REQ-034 SHALL cover: both starts in the same cycle with the REQ-032/033 operands -> kw bytes issued in cycles 1,3,5,7 and st bytes in cycles 2,4,6,8,9..20; kw_done in cycle 12, st_done in cycle 25, with outputs as above.
REQ-035 SHALL cover: st_start again in cycle 5 of a running state job -> ignored, and the original job completes unchanged in cycle 21.
REQ-036 SHALL cover: rst pulsed in cycle 10 of a state job -> no st_done, st_busy=0 and st_out=0 from the following cycle, and a fresh kw job afterwards completes at uncontended latency.
REQ-037 SHALL cover: randomized back-to-back starts across SBOX_LAT values 1, 4 and 8 -> every output matches a byte-wise S-box reference model, with exactly one done per accepted start.
